montinv_ctrl: RTL and testbench

- Sequencer for the phase-1 almost-Montgomery-inverse core (ports ainv/exp/vld).
- Validates operands, launches the core, and captures r = a^-1·2^k mod p.
- Runs phase-2 correction with one halve or double per cycle.
- Returns either the plain modular inverse or the Montgomery-domain inverse (a^-1·2^NBITS mod p) to the ECC sequencer.

---
 rtl/montinv_ctrl_if.sv | 37 +++
 rtl/montinv_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_montinv_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/montinv_ctrl_if.sv
// montinv_ctrl_if: request/response bus between the ECC sequencer and the
// inverse sequencer, bundled with the launch/result handshake of the phase-1
// almost-Montgomery-inverse core.
// slave  : the montinv_ctrl side (drives busy/done/err/dout and core launch).
// master : the environment side (ECC sequencer plus the phase-1 core).
interface montinv_ctrl_if #(
    parameter int WIDTH = 256,
    parameter int CWID  = 10
);
    // ECC sequencer side
    logic             start;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] mod;
    logic             mode;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] dout;

    // phase-1 core side
    logic             core_en;
    logic [WIDTH-1:0] core_din;
    logic [WIDTH-1:0] core_mod;
    logic [WIDTH-1:0] core_ainv;
    logic [CWID-1:0]  core_exp;
    logic             core_vld;

    modport slave (
        input  start, din, mod, mode, core_ainv, core_exp, core_vld,
        output busy, done, err, dout, core_en, core_din, core_mod
    );

    modport master (
        output start, din, mod, mode, core_ainv, core_exp, core_vld,
        input  busy, done, err, dout, core_en, core_din, core_mod
    );
endinterface

// File: rtl/montinv_ctrl.sv
// montinv_ctrl: sequencer around the phase-1 almost-Montgomery-inverse core.
// Validates a and p, launches the core, captures r = a^-1*2^k mod p and then
// walks r to either a^-1 mod p (mode=0) or a^-1*2^NBITS mod p (mode=1) with
// one modular halve or double per cycle.
// Optional build macro MONTINV_TMO_EN adds a WAIT-state watchdog of TMO cycles
// that ends the operation with err=1 when the core never answers.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for start; operands latched and checked on start
// S_LOAD | core_en pulse (one cycle)
// S_WAIT | waiting for core_vld; r and k captured, correction planned
// S_CORR | cnt halve/double steps on r, then dout <- r
// S_FIN  | done=1, err=0
// S_ERR  | done=1, err=1, dout=0 (bad operand or watchdog)
module montinv_ctrl #(
    parameter int WIDTH = 256,
    parameter int CWID  = 10,
    parameter int NBITS = 256,
    parameter int TMO   = 1032
) (
    input  logic           clk_i,
    input  logic           rst_i,
    montinv_ctrl_if.slave  ctrl_if
);

    // Parameter sanity: the correction counter must be able to hold NBITS.
    if (NBITS > WIDTH || NBITS >= (2 ** CWID) || TMO < 1) begin : g_bad_param
        $error("montinv_ctrl: inconsistent WIDTH/CWID/NBITS/TMO");
    end

    localparam logic [CWID-1:0] NBITS_C = CWID'(NBITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_CORR,
        S_FIN,
        S_ERR
    } state_t;

    state_t           state_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic [WIDTH-1:0] dout_q;
    logic             core_en_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] p_q;
    logic             mode_q;
    logic [WIDTH-1:0] r_q;
    logic [CWID-1:0]  cnt_q;
    logic             dir_q;          // 0 = halve, 1 = double

`ifdef MONTINV_TMO_EN
    localparam int TMO_W = $clog2(TMO + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO - 1);
    logic [TMO_W-1:0] tmo_q;
`endif

    logic [WIDTH:0]   half_sum_d;
    logic [WIDTH:0]   dbl_t_d;
    logic [WIDTH:0]   dbl_sub_d;
    logic [WIDTH-1:0] r_step_d;
    logic             bad_op_d;

    // One correction step on r; both branches keep r inside [0, p).
    always_comb begin
        half_sum_d = {1'b0, r_q} + {1'b0, p_q};
        dbl_t_d    = {r_q, 1'b0};
        dbl_sub_d  = dbl_t_d - {1'b0, p_q};
        r_step_d   = r_q;
        if (dir_q) begin
            r_step_d = (dbl_t_d >= {1'b0, p_q}) ? WIDTH'(dbl_sub_d) : WIDTH'(dbl_t_d);
        end else begin
            r_step_d = r_q[0] ? WIDTH'(half_sum_d >> 1) : WIDTH'(r_q >> 1);
        end
    end

    // Operand check done on the raw bus so the decision is made in the start cycle.
    always_comb begin
        bad_op_d = (ctrl_if.din == '0) || (ctrl_if.din >= ctrl_if.mod) || !ctrl_if.mod[0];
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            dout_q    <= '0;
            core_en_q <= 1'b0;
            a_q       <= '0;
            p_q       <= '0;
            mode_q    <= 1'b0;
            r_q       <= '0;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
`ifdef MONTINV_TMO_EN
            tmo_q     <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (ctrl_if.start) begin
                        a_q    <= ctrl_if.din;
                        p_q    <= ctrl_if.mod;
                        mode_q <= ctrl_if.mode;
                        busy_q <= 1'b1;
                        if (bad_op_d) begin
                            state_q <= S_ERR;
                            dout_q  <= '0;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q   <= S_LOAD;
                            core_en_q <= 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    core_en_q <= 1'b0;
                    state_q   <= S_WAIT;
`ifdef MONTINV_TMO_EN
                    tmo_q     <= '0;
`endif
                end

                S_WAIT: begin
                    if (ctrl_if.core_vld) begin
                        // vld wins over a watchdog expiring in the same cycle
                        r_q     <= ctrl_if.core_ainv;
                        state_q <= S_CORR;
                        if (!mode_q) begin
                            cnt_q <= ctrl_if.core_exp;
                            dir_q <= 1'b0;
                        end else if (ctrl_if.core_exp >= NBITS_C) begin
                            cnt_q <= ctrl_if.core_exp - NBITS_C;
                            dir_q <= 1'b0;
                        end else begin
                            cnt_q <= NBITS_C - ctrl_if.core_exp;
                            dir_q <= 1'b1;
                        end
`ifdef MONTINV_TMO_EN
                    end else if (tmo_q == TMO_LAST) begin
                        state_q <= S_ERR;
                        dout_q  <= '0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
`endif
                    end
                end

                S_CORR: begin
                    if (cnt_q == '0) begin
                        dout_q  <= r_q;
                        done_q  <= 1'b1;
                        err_q   <= 1'b0;
                        state_q <= S_FIN;
                    end else begin
                        r_q   <= r_step_d;
                        cnt_q <= cnt_q - CWID'(1);
                    end
                end

                S_FIN, S_ERR: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q   <= S_IDLE;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    err_q     <= 1'b0;
                    core_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign ctrl_if.busy     = busy_q;
    assign ctrl_if.done     = done_q;
    assign ctrl_if.err      = err_q;
    assign ctrl_if.dout     = dout_q;
    assign ctrl_if.core_en  = core_en_q;
    assign ctrl_if.core_din = a_q;
    assign ctrl_if.core_mod = p_q;

endmodule

// File: tb/tb_montinv_ctrl.sv
// tb_montinv_ctrl: scoreboard bench for montinv_ctrl with a phase-1 core stub.
// The stub answers a launch with r = a^-1*2^k mod p for a chosen k after a
// chosen latency; expected results come from a brute-force modular model.
module tb_montinv_ctrl;
    localparam int W     = 8;
    localparam int CW    = 6;
    localparam int NB    = 8;
    localparam int TMO_L = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    montinv_ctrl_if #(.WIDTH(W), .CWID(CW)) bus ();

    montinv_ctrl #(.WIDTH(W), .CWID(CW), .NBITS(NB), .TMO(TMO_L)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .ctrl_if (bus.slave)
    );

    typedef struct {
        logic [W-1:0] dout;
        logic         err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    int   en_cnt = 0;
    int   stub_lat = 2;
    int   stub_k = 3;
    bit   stub_hang = 1'b0;
    bit   stray_req = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int inv_mod(input int a, input int p);
        for (int x = 1; x < p; x++) if ((a * x) % p == 1) return x;
        return 0;
    endfunction

    function automatic int pow2_mul(input int x, input int k, input int p);
        int r = x;
        for (int i = 0; i < k; i++) r = (2 * r) % p;
        return r;
    endfunction

    // Phase-1 core stub
    initial begin
        bus.core_vld  = 1'b0;
        bus.core_ainv = '0;
        bus.core_exp  = '0;
        forever begin
            @(negedge clk);
            if (stray_req) begin
                bus.core_ainv = 8'd9;
                bus.core_exp  = 6'd2;
                bus.core_vld  = 1'b1;
                @(negedge clk);
                bus.core_vld  = 1'b0;
            end else if (bus.core_en && !stub_hang) begin
                repeat (stub_lat) @(negedge clk);
                bus.core_ainv = W'(pow2_mul(inv_mod(int'(bus.core_din), int'(bus.core_mod)),
                                            stub_k, int'(bus.core_mod)));
                bus.core_exp  = CW'(stub_k);
                bus.core_vld  = 1'b1;
                @(negedge clk);
                bus.core_vld  = 1'b0;
            end
        end
    end

    // Output monitor: pops the scoreboard on every done pulse
    always @(negedge clk) begin
        if (bus.core_en) en_cnt++;
        if (bus.done) begin
            done_cnt++;
            chk("sb_nonempty", 32'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                chk("dout", 32'(bus.dout), 32'(mon_e.dout));
                chk("err", 32'(bus.err), 32'(mon_e.err));
            end
        end
    end

    task automatic drive_start(input int a, input int p, input int m);
        @(negedge clk);
        bus.din   = W'(a);
        bus.mod   = W'(p);
        bus.mode  = m[0];
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_op(input int a, input int p, input int m, input int k,
                          input int lat, input bit spam, input bit tmo);
        bit valid;
        int e_d, e_cyc, en0, d0, cyc;
        bit got;
        valid = (a != 0) && (a < p) && (p % 2 == 1);
        e_d   = (valid && !tmo) ? pow2_mul(inv_mod(a, p), m ? NB : 0, p) : 0;
        if (!valid)   e_cyc = 0;
        else if (tmo) e_cyc = 1 + TMO_L;
        else          e_cyc = 2 + lat + ((m == 0) ? k : ((k >= NB) ? k - NB : NB - k));
        sb_q.push_back('{dout: W'(e_d), err: (!valid) || tmo});
        stub_k   = k;
        stub_lat = lat;
        en0 = en_cnt;
        d0  = done_cnt;
        drive_start(a, p, m);
        chk("busy_run", 32'(bus.busy), 1);
        got = 1'b0;
        cyc = 0;
        for (int i = 0; i < 600 && !got; i++) begin
            if (bus.done) begin
                got = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
                if (spam) begin
                    bus.start = ~bus.start;
                    bus.din   = 8'hAA;
                end
            end
        end
        chk("done_seen", 32'(got), 1);
        if (!got) sb_q.delete();
        chk("latency", 32'(cyc), 32'(e_cyc));
        if (spam) bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("done_pulse", 32'(bus.done), 0);
        repeat (4) @(negedge clk);
        chk("dout_hold", 32'(bus.dout), 32'(e_d));
        chk("busy_idle", 32'(bus.busy), 0);
        chk("core_en_count", 32'(en_cnt - en0), valid ? 1 : 0);
        chk("done_count", 32'(done_cnt - d0), 1);
    endtask

    task automatic reset_in_corr();
        int d0;
        bit seen;
        stub_k   = 40;
        stub_lat = 2;
        drive_start(5, 23, 0);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (bus.core_vld) seen = 1'b1;
        end
        chk("rst_vld_seen", 32'(seen), 1);
        repeat (5) @(negedge clk);
        chk("rst_busy_corr", 32'(bus.busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_dout", 32'(bus.dout), 0);
        chk("rst_core_en", 32'(bus.core_en), 0);
        chk("rst_core_din", 32'(bus.core_din), 0);
        chk("rst_core_mod", 32'(bus.core_mod), 0);
        rst = 1'b0;
        d0 = done_cnt;
        @(posedge clk);
        stray_req = 1'b1;
        @(posedge clk);
        stray_req = 1'b0;
        repeat (10) @(negedge clk);
        chk("stray_done", 32'(done_cnt - d0), 0);
        chk("stray_busy", 32'(bus.busy), 0);
        chk("stray_dout", 32'(bus.dout), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0;
        bus.din   = '0;
        bus.mod   = '0;
        bus.mode  = 1'b0;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_done", 32'(bus.done), 0);
        chk("reset_err", 32'(bus.err), 0);
        chk("reset_dout", 32'(bus.dout), 0);
        chk("reset_core_en", 32'(bus.core_en), 0);
        chk("reset_core_din", 32'(bus.core_din), 0);
        chk("reset_core_mod", 32'(bus.core_mod), 0);
        rst = 1'b0;
        @(negedge clk);

        //      a   p  m   k lat spam tmo
        run_op( 5, 23, 0,  3, 2, 0, 0);   // 14
        run_op( 5, 23, 1,  3, 1, 0, 0);   // 19 via doubling
        run_op( 5, 23, 1, 12, 3, 0, 0);   // 19 via halving
        run_op( 5, 23, 1,  8, 2, 0, 0);   // 19, no correction steps
        run_op( 1, 23, 0,  0, 1, 0, 0);   // 1
        run_op(22, 23, 0,  8, 4, 0, 0);   // 22
        run_op( 0, 23, 0,  3, 2, 0, 0);   // invalid: a=0
        run_op(23, 23, 0,  3, 2, 0, 0);   // invalid: a>=p
        run_op( 5, 24, 0,  3, 2, 0, 0);   // invalid: even p
        run_op( 5, 23, 0,  5, 3, 1, 0);   // start spam ignored, 14

        reset_in_corr();
        run_op( 7, 23, 0, 10, 2, 0, 0);   // recovery after reset, 10

`ifdef MONTINV_TMO_EN
        stub_hang = 1'b1;
        run_op( 5, 23, 0,  3, 1, 0, 1);   // watchdog expires
        stub_hang = 1'b0;
        run_op( 5, 23, 1,  3, 2, 0, 0);   // normal again, 19
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
